// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: command op encoding, IEEE 1149.1 TAP states and
// the TAP next-state function used to track the chain's controllers.
package jtag_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'b00,
        OP_SHIFT_IR  = 2'b01,
        OP_SHIFT_DR  = 2'b10,
        OP_IDLE      = 2'b11
    } jtag_op_t;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET,
        RUN_TEST_IDLE,
        SELECT_DR_SCAN,
        CAPTURE_DR,
        SHIFT_DR,
        EXIT1_DR,
        PAUSE_DR,
        EXIT2_DR,
        UPDATE_DR,
        SELECT_IR_SCAN,
        CAPTURE_IR,
        SHIFT_IR,
        EXIT1_IR,
        PAUSE_IR,
        EXIT2_IR,
        UPDATE_IR
    } tap_state_t;

    function automatic tap_state_t next_tap_state(tap_state_t state, logic tms);
        tap_state_t nxt;
        nxt = TEST_LOGIC_RESET;
        case (state)
            TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          nxt = TEST_LOGIC_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: CLK_DIV CLKs low then CLK_DIV CLKs high while enabled,
// with one-CLK strobes flagging the CLK edge on which TCK rises or falls.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase_end;

    assign phase_end = en && (cnt == CNT_LAST);
    assign tck_rise  = phase_end && !tck;
    assign tck_fall  = phase_end && tck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (phase_end) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/jtag_tap_master.sv
// JTAG initiator: turns reset / shift-IR / shift-DR / idle commands into TCK,
// TMS and TDI sequences and returns the TDO bits captured during shifting.
module jtag_tap_master
    import jtag_pkg::*;
#(
    parameter  int MAX_LEN = 32,
    parameter  int CLK_DIV = 2,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [1:0]         CMD_OP,
    input  logic [LEN_W-1:0]   CMD_LEN,
    input  logic [MAX_LEN-1:0] CMD_DATA,
    output logic               RSP_VALID,
    output logic [MAX_LEN-1:0] RSP_DATA,
    output logic               BUSY,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);

    localparam int CYC_W = LEN_W + 1;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic {M_IDLE, M_RUN} mst_state_t;

    mst_state_t         mst_state;
    logic               busy_q;
    jtag_op_t           op_q;
    logic [LEN_W-1:0]   len_m1;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] cap_q;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [CYC_W-1:0]   cyc_last;
    logic [LEN_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   bit_pos;
    tap_state_t         tap_state;
    logic               tms_q;
    logic               tdi_q;
    logic               rsp_valid_q;
    logic [MAX_LEN-1:0] rsp_data_q;
    logic               tck_rise;
    logic               tck_fall;

    jtag_op_t           cmd_op_e;
    logic [LEN_W-1:0]   len_eff;
    logic [CYC_W-1:0]   cyc_last_d;

    jtag_tck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tck_gen (
        .clk     (CLK),
        .rst_n   (RST_N),
        .en      (busy_q),
        .tck     (TCK),
        .tck_rise(tck_rise),
        .tck_fall(tck_fall)
    );

    // Length normalisation and total TCK cycle count (minus one) per op.
    always_comb begin
        cmd_op_e = jtag_op_t'(CMD_OP);
        len_eff  = CMD_LEN;
        if (CMD_LEN == '0) begin
            len_eff = LEN_W'(1);
        end else if (CMD_LEN > LEN_W'(MAX_LEN)) begin
            len_eff = LEN_W'(MAX_LEN);
        end
        case (cmd_op_e)
            OP_TAP_RESET: cyc_last_d = CYC_W'(5);
            OP_SHIFT_IR:  cyc_last_d = CYC_W'(len_eff) + CYC_W'(5);
            OP_SHIFT_DR:  cyc_last_d = CYC_W'(len_eff) + CYC_W'(4);
            default:      cyc_last_d = CYC_W'(len_eff) - CYC_W'(1);
        endcase
    end

    function automatic logic is_shift(tap_state_t st);
        return (st == SHIFT_DR) || (st == SHIFT_IR);
    endfunction

    // TMS for the TCK cycle spent in tap state st; scans walk the TAP graph.
    function automatic logic tms_for(jtag_op_t op, tap_state_t st,
                                     logic [CYC_W-1:0] cyc, logic last_bit);
        logic tms;
        tms = 1'b0;
        case (op)
            OP_TAP_RESET: tms = (cyc < CYC_W'(5));
            OP_IDLE:      tms = 1'b0;
            default: begin
                case (st)
                    RUN_TEST_IDLE, EXIT1_DR, EXIT1_IR: tms = 1'b1;
                    SELECT_DR_SCAN:                    tms = (op == OP_SHIFT_IR);
                    SHIFT_DR, SHIFT_IR:                tms = last_bit;
                    default:                           tms = 1'b0;
                endcase
            end
        endcase
        return tms;
    endfunction

    assign bit_pos = bit_idx[IDX_W-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mst_state   <= M_IDLE;
            busy_q      <= 1'b0;
            op_q        <= OP_TAP_RESET;
            len_m1      <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            cyc_cnt     <= '0;
            cyc_last    <= '0;
            bit_idx     <= '0;
            tap_state   <= TEST_LOGIC_RESET;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (mst_state)
                M_IDLE: begin
                    if (CMD_VALID) begin
                        mst_state <= M_RUN;
                        busy_q    <= 1'b1;
                        op_q      <= cmd_op_e;
                        len_m1    <= len_eff - LEN_W'(1);
                        data_q    <= CMD_DATA;
                        cap_q     <= '0;
                        cyc_cnt   <= '0;
                        cyc_last  <= cyc_last_d;
                        bit_idx   <= '0;
                        tms_q     <= tms_for(cmd_op_e, tap_state, '0, 1'b0);
                        tdi_q     <= 1'b0;
                    end
                end
                M_RUN: begin
                    if (tck_rise) begin
                        if (is_shift(tap_state)) begin
                            cap_q[bit_pos] <= TDO;
                            bit_idx        <= bit_idx + LEN_W'(1);
                        end
                        tap_state <= next_tap_state(tap_state, tms_q);
                    end
                    // tap_state already reflects the cycle this falling edge opens.
                    if (tck_fall) begin
                        if (cyc_cnt == cyc_last) begin
                            mst_state   <= M_IDLE;
                            busy_q      <= 1'b0;
                            tms_q       <= 1'b0;
                            tdi_q       <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= cap_q;
                        end else begin
                            cyc_cnt <= cyc_cnt + CYC_W'(1);
                            tms_q   <= tms_for(op_q, tap_state, cyc_cnt + CYC_W'(1),
                                               bit_idx == len_m1);
                            tdi_q   <= is_shift(tap_state) ? data_q[bit_pos] : 1'b0;
                        end
                    end
                end
                default: mst_state <= M_IDLE;
            endcase
        end
    end

    assign CMD_READY = !busy_q;
    assign BUSY      = busy_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;

endmodule

// File: tb/tb_jtag_tap_master.sv
// Directed bench for jtag_tap_master: TMS/TDI per TCK cycle, captured TDO,
// latency, back-to-back acceptance and asynchronous reset mid-command.
module tb_jtag_tap_master;

    localparam int MAX_LEN = 32;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 6;

    logic               CLK = 1'b0;
    logic               RST_N = 1'b0;
    logic               CMD_VALID = 1'b0;
    logic               CMD_READY;
    logic [1:0]         CMD_OP = '0;
    logic [LEN_W-1:0]   CMD_LEN = '0;
    logic [MAX_LEN-1:0] CMD_DATA = '0;
    logic               RSP_VALID;
    logic [MAX_LEN-1:0] RSP_DATA;
    logic               BUSY;
    logic               TCK;
    logic               TMS;
    logic               TDI;
    logic               TDO;

    int tests_run = 0;
    int tests_failed = 0;

    bit   tms_log[$];
    bit   tdi_log[$];
    int   tck_cycles = 0;
    int   win_lo = -1;
    int   win_hi = -1;
    int   tdo_mode = 0;
    logic [3:0] sreg = '0;
    logic loop_q = 1'b0;
    logic tdi_at_rise = 1'b0;

    always #5 CLK = ~CLK;

    jtag_tap_master #(
        .MAX_LEN(MAX_LEN),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_OP   (CMD_OP),
        .CMD_LEN  (CMD_LEN),
        .CMD_DATA (CMD_DATA),
        .RSP_VALID(RSP_VALID),
        .RSP_DATA (RSP_DATA),
        .BUSY     (BUSY),
        .TCK      (TCK),
        .TMS      (TMS),
        .TDI      (TDI),
        .TDO      (TDO)
    );

    // Chain model: 1 = 4-bit register LSB first, 2 = 1-bit TDI loopback, 3 = constant 1.
    assign TDO = (tdo_mode == 1) ? sreg[0] :
                 (tdo_mode == 2) ? loop_q  : (tdo_mode == 3);

    always @(posedge TCK) begin
        tms_log.push_back(TMS);
        tdi_log.push_back(TDI);
        tdi_at_rise = TDI;
        tck_cycles++;
    end

    always @(negedge TCK) begin
        int c;
        c = tck_cycles - 1;
        if (c >= win_lo && c <= win_hi) begin
            if (tdo_mode == 1) sreg = sreg >> 1;
            if (tdo_mode == 2) loop_q = tdi_at_rise;
        end
    end

    task automatic clear_log();
        tms_log.delete();
        tdi_log.delete();
        tck_cycles = 0;
    endtask

    // First recorded cycle lands in the most significant used bit.
    function automatic logic [63:0] pack_log(input bit want_tdi);
        logic [63:0] v;
        int n;
        v = '0;
        n = want_tdi ? tdi_log.size() : tms_log.size();
        for (int i = 0; i < n; i++) v = {v[62:0], (want_tdi ? tdi_log[i] : tms_log[i])};
        return v;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [LEN_W-1:0] len,
                         input logic [MAX_LEN-1:0] data);
        @(negedge CLK);
        CMD_OP    = op;
        CMD_LEN   = len;
        CMD_DATA  = data;
        CMD_VALID = 1'b1;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'($urandom);
        CMD_LEN   = LEN_W'($urandom);
        CMD_DATA  = $urandom;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge CLK);
            #1;
            if (RSP_VALID) begin
                lat = i;
                return;
            end
        end
        lat = -1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        tests_run++; if (TCK !== 1'b0) begin tests_failed++; $display("FAIL reset_tck got %b want 0", TCK); end
        tests_run++; if (TMS !== 1'b1) begin tests_failed++; $display("FAIL reset_tms got %b want 1", TMS); end
        tests_run++; if (TDI !== 1'b0) begin tests_failed++; $display("FAIL reset_tdi got %b want 0", TDI); end
        tests_run++; if (CMD_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", CMD_READY); end
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", BUSY); end
        tests_run++; if (RSP_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got %b want 0", RSP_VALID); end
        tests_run++; if (RSP_DATA !== '0) begin tests_failed++; $display("FAIL reset_rsp_data got %h want 0", RSP_DATA); end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        tests_run++; if (TMS !== 1'b1 || TCK !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle got tms=%b tck=%b want 1/0", TMS, TCK); end
    endtask

    task automatic test_tap_reset();
        int lat;
        tdo_mode = 0;
        clear_log();
        issue(2'b00, 6'd0, 32'h0);
        tests_run++; if (BUSY !== 1'b1 || CMD_READY !== 1'b0) begin tests_failed++; $display("FAIL tap_reset_busy got busy=%b ready=%b want 1/0", BUSY, CMD_READY); end
        wait_rsp(lat);
        tests_run++; if (lat !== 24) begin tests_failed++; $display("FAIL tap_reset_latency got %0d want 24", lat); end
        tests_run++; if (BUSY !== 1'b0 || CMD_READY !== 1'b1) begin tests_failed++; $display("FAIL tap_reset_done got busy=%b ready=%b want 0/1", BUSY, CMD_READY); end
        tests_run++; if (tms_log.size() !== 6) begin tests_failed++; $display("FAIL tap_reset_cycles got %0d want 6", tms_log.size()); end
        tests_run++; if (pack_log(1'b0) !== 64'b111110) begin tests_failed++; $display("FAIL tap_reset_tms got %b want 111110", pack_log(1'b0)); end
        tests_run++; if (pack_log(1'b1) !== 64'b0) begin tests_failed++; $display("FAIL tap_reset_tdi got %b want 0", pack_log(1'b1)); end
        tests_run++; if (RSP_DATA !== 32'h0) begin tests_failed++; $display("FAIL tap_reset_rsp got %h want 0", RSP_DATA); end
    endtask

    task automatic test_shift_ir();
        int lat;
        sreg = 4'h5;
        tdo_mode = 1;
        win_lo = 4;
        win_hi = 7;
        clear_log();
        issue(2'b01, 6'd4, 32'hA);
        wait_rsp(lat);
        tests_run++; if (lat !== 40) begin tests_failed++; $display("FAIL ir_latency got %0d want 40", lat); end
        tests_run++; if (tms_log.size() !== 10) begin tests_failed++; $display("FAIL ir_cycles got %0d want 10", tms_log.size()); end
        tests_run++; if (pack_log(1'b0) !== 64'b1100000110) begin tests_failed++; $display("FAIL ir_tms got %b want 1100000110", pack_log(1'b0)); end
        tests_run++; if (pack_log(1'b1) !== 64'b0000010100) begin tests_failed++; $display("FAIL ir_tdi got %b want 0000010100", pack_log(1'b1)); end
        tests_run++; if (RSP_DATA !== 32'h5) begin tests_failed++; $display("FAIL ir_rsp got %h want 00000005", RSP_DATA); end
        repeat (5) @(posedge CLK);
        #1;
        tests_run++; if (RSP_DATA !== 32'h5 || RSP_VALID !== 1'b0) begin tests_failed++; $display("FAIL ir_rsp_hold got %h/%b want 00000005/0", RSP_DATA, RSP_VALID); end
    endtask

    task automatic test_shift_dr();
        int lat;
        loop_q = 1'b1;
        tdo_mode = 2;
        win_lo = 3;
        win_hi = 34;
        clear_log();
        issue(2'b10, 6'd32, 32'hDEADBEEF);
        wait_rsp(lat);
        tests_run++; if (lat !== 148) begin tests_failed++; $display("FAIL dr_latency got %0d want 148", lat); end
        tests_run++; if (tms_log.size() !== 37) begin tests_failed++; $display("FAIL dr_cycles got %0d want 37", tms_log.size()); end
        tests_run++;
        if (pack_log(1'b0) !== 64'b100_0000000000_0000000000_0000000000_0_1_10) begin
            tests_failed++; $display("FAIL dr_tms got %b want 1 0 0, 31x0, 1 1 0", pack_log(1'b0));
        end
        tests_run++; if (RSP_DATA !== 32'hBD5B7DDF) begin tests_failed++; $display("FAIL dr_rsp got %h want bd5b7ddf", RSP_DATA); end
    endtask

    task automatic test_idle_clocks();
        int lat;
        tdo_mode = 3;
        win_lo = -1;
        win_hi = -1;
        clear_log();
        issue(2'b11, 6'd3, 32'hFFFFFFFF);
        wait_rsp(lat);
        tests_run++; if (lat !== 12) begin tests_failed++; $display("FAIL idle_latency got %0d want 12", lat); end
        tests_run++; if (tms_log.size() !== 3) begin tests_failed++; $display("FAIL idle_cycles got %0d want 3", tms_log.size()); end
        tests_run++; if (pack_log(1'b0) !== 64'b0 || pack_log(1'b1) !== 64'b0) begin tests_failed++; $display("FAIL idle_tms_tdi got tms=%b tdi=%b want 0/0", pack_log(1'b0), pack_log(1'b1)); end
        tests_run++; if (RSP_DATA !== 32'h0) begin tests_failed++; $display("FAIL idle_rsp got %h want 0", RSP_DATA); end
    endtask

    task automatic test_back_to_back();
        int lat;
        tdo_mode = 3;
        win_lo = -1;
        win_hi = -1;
        clear_log();
        @(negedge CLK);
        CMD_OP    = 2'b10;
        CMD_LEN   = 6'd8;
        CMD_DATA  = 32'h3C;
        CMD_VALID = 1'b1;
        @(posedge CLK);
        #1;
        CMD_LEN  = 6'd4;
        CMD_DATA = 32'h9;
        tests_run++; if (BUSY !== 1'b1 || CMD_READY !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_a got busy=%b ready=%b want 1/0", BUSY, CMD_READY); end
        wait_rsp(lat);
        tests_run++; if (lat !== 52) begin tests_failed++; $display("FAIL b2b_latency_a got %0d want 52", lat); end
        tests_run++; if (RSP_DATA !== 32'hFF) begin tests_failed++; $display("FAIL b2b_rsp_a got %h want 000000ff", RSP_DATA); end
        tests_run++; if (CMD_READY !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_in_rsp got %b want 1", CMD_READY); end
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        tests_run++; if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept_b got busy=%b want 1", BUSY); end
        wait_rsp(lat);
        tests_run++; if (lat !== 36) begin tests_failed++; $display("FAIL b2b_latency_b got %0d want 36", lat); end
        tests_run++; if (RSP_DATA !== 32'hF) begin tests_failed++; $display("FAIL b2b_rsp_b got %h want 0000000f", RSP_DATA); end
        tests_run++; if (tms_log.size() !== 22) begin tests_failed++; $display("FAIL b2b_cycles got %0d want 22", tms_log.size()); end
        tests_run++; if (pack_log(1'b0) !== 64'b1000000000110_100000110) begin tests_failed++; $display("FAIL b2b_tms got %b want 1000000000110100000110", pack_log(1'b0)); end
        tests_run++; if (pack_log(1'b1) !== 64'b0000011110000_000100100) begin tests_failed++; $display("FAIL b2b_tdi got %b want 0000011110000000100100", pack_log(1'b1)); end
    endtask

    task automatic test_reset_mid_dr();
        int lat;
        bit seen;
        tdo_mode = 0;
        win_lo = -1;
        win_hi = -1;
        clear_log();
        issue(2'b10, 6'd32, 32'h12345678);
        repeat (60) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        tests_run++; if (TCK !== 1'b0 || TMS !== 1'b1) begin tests_failed++; $display("FAIL midrst_pins got tck=%b tms=%b want 0/1", TCK, TMS); end
        tests_run++; if (BUSY !== 1'b0 || CMD_READY !== 1'b1 || TDI !== 1'b0) begin tests_failed++; $display("FAIL midrst_status got busy=%b ready=%b tdi=%b want 0/1/0", BUSY, CMD_READY, TDI); end
        seen = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (RSP_VALID) seen = 1'b1;
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (30) begin
            @(posedge CLK);
            #1;
            if (RSP_VALID) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL midrst_no_rsp got %b want 0", seen); end
        tests_run++; if (RSP_DATA !== 32'h0) begin tests_failed++; $display("FAIL midrst_rsp_data got %h want 0", RSP_DATA); end
        clear_log();
        issue(2'b00, 6'd1, 32'h0);
        wait_rsp(lat);
        tests_run++; if (lat !== 24) begin tests_failed++; $display("FAIL midrst_reset_latency got %0d want 24", lat); end
        tests_run++; if (pack_log(1'b0) !== 64'b111110 || tms_log.size() !== 6) begin tests_failed++; $display("FAIL midrst_reset_tms got %b (%0d cycles) want 111110", pack_log(1'b0), tms_log.size()); end
    endtask

    initial begin
        test_reset();
        test_tap_reset();
        test_shift_ir();
        test_shift_dr();
        test_idle_clocks();
        test_back_to_back();
        test_reset_mid_dr();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
